change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter COIN_PULSE_CYCLES, default 4, sets the coin_strobe width in clock cycles (range 1..15).
REQ-002 Parameter ACK_TIMEOUT, default 16, sets the maximum number of cycles spent in WAIT_ACK before a jam error.
REQ-003 Parameter MAX_CHANGE, default 99, sets the largest amount accepted.
REQ-004 Parameter INV_INIT, default 8, sets the coins per denomination after reset or refill (range 0..15).
REQ-005 One clock; reset is synchronous and active-high: clk input 1 is the system clock; reset input 1 is the synchronous active-high reset.
REQ-006 Inputs: change_valid (1, request strobe); change_amt (8, change amount in units); coin_done (1, hopper sensor acknowledge for one ejected coin); refill (1, restore inventory).
REQ-007 Outputs: change_ready (1); coin_out (2, denomination code: 01=5, 10=10, 11=20, 00=none); coin_strobe (1, eject command); remaining (8, undispensed amount); done (1); error (1); state_out (3).

Function
REQ-008 States and state_out encodings shall be IDLE=0, SELECT=1, PULSE=2, WAIT_ACK=3, DONE=4 and ERROR=5.
REQ-009 change_ready shall be 1 only in IDLE; a request is accepted on a cycle with change_valid and change_ready, which loads remaining, clears error and enters SELECT.
REQ-010 Accepting a change_amt that is not a multiple of 5 or exceeds MAX_CHANGE shall enter ERROR with remaining = change_amt and no coin dispensed.
REQ-011 SELECT shall behave as follows:
- remaining==0 enters DONE.
- Otherwise choose the largest denomination that is <= remaining and has inventory >0, then enter PULSE.
- If no denomination qualifies, enter ERROR.
REQ-012 PULSE shall hold coin_strobe=1 and coin_out stable for exactly COIN_PULSE_CYCLES cycles, then enter WAIT_ACK with coin_strobe=0 and coin_out held.
REQ-013 A coin_done in WAIT_ACK shall subtract the denomination from remaining, decrement that inventory and return to SELECT; coin_done in any other state shall be ignored.
REQ-014 ACK_TIMEOUT cycles in WAIT_ACK without coin_done shall enter ERROR (jam) with remaining and inventory unchanged.
REQ-015 DONE shall assert done for exactly one cycle, then enter IDLE.
REQ-016 ERROR shall last one cycle, then enter IDLE; error is set on entry and stays 1 until the next accepted request or reset.
REQ-017 refill shall set all three inventories to INV_INIT only in IDLE and is ignored in other states.
- When refill and an accepted request occur in the same cycle, the refill applies first.
REQ-018 Greedy order 20, 10, 5 is mandatory; remaining shall never underflow.

Reset
REQ-019 Reset shall force IDLE, coin_out=00, coin_strobe=0, remaining=0, done=0, error=0, change_ready=1 and inventories=INV_INIT on the next clock edge from any state, aborting a dispense in progress.

Configuration
REQ-020 With HOPPER_INV_EN defined, the per-denomination 4-bit inventory counters are built and REQ-011 and REQ-017 apply as written.
REQ-021 Without HOPPER_INV_EN, no counters are built, every denomination is treated as always available, refill is ignored, and SELECT reaches ERROR only through REQ-010.

Structure
REQ-022 A shared package vending_pkg shall hold the coin code constants, the denomination values (5/10/20), and the state type with its encodings, all shared with vending_machine.
REQ-023 The inventory counters shall be a sub-module change_hopper_inv, instantiated only under HOPPER_INV_EN.

Verification
REQ-024 The bench shall cover these directed scenarios:
- Defaults, request 35, coin_done 2 cycles after each strobe -> coins 11, 10, 01 in order; done pulse; remaining=0; error=0.
- Request 7 -> ERROR next cycle; error=1; no coin_strobe; remaining=7.
- HOPPER_INV_EN, INV_INIT=1, request 45 -> 11, 10, 01 dispensed, then error=1 with remaining=10.
- Request 20, coin_done never asserted -> error=1 after 4+16 cycles; state_out returns to 0; remaining=20.
- Request 0 -> done=1 two cycles after acceptance; no strobe.
- Reset asserted mid-PULSE -> coin_strobe=0 and remaining=0 after the next edge; change_ready=1.

Source files
------------

// File: rtl/vending_pkg.sv
// vending_pkg: shared definitions for the vending datapath blocks
// (change_dispenser, vending_machine).
//   - coin denomination codes driven on coin_out
//   - denomination values in units
//   - controller state type; the encodings are visible on state_out
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam logic [7:0] VAL_5  = 8'd5;
  localparam logic [7:0] VAL_10 = 8'd10;
  localparam logic [7:0] VAL_20 = 8'd20;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_PULSE    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } state_t;

  // Unit value of a coin code; COIN_NONE is worth nothing.
  function automatic logic [7:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  return VAL_5;
      COIN_10: return VAL_10;
      COIN_20: return VAL_20;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request / hopper handshake bundle of the change
// dispenser.
//   master : requester + hopper side (drives request, coin_done, refill)
//   slave  : dispenser side (drives ready, coin command, status)
//   change_valid/change_amt : change request and amount in units
//   change_ready            : dispenser is idle and takes a request
//   coin_out/coin_strobe    : coin code and eject command to the hopper
//   coin_done               : hopper acknowledge for one ejected coin
//   refill                  : restore hopper inventory
//   remaining/done/error    : undispensed amount and completion status
//   state_out               : controller state encoding
interface change_dispenser_if;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       coin_done;
  logic       refill;
  logic       change_ready;
  logic [1:0] coin_out;
  logic       coin_strobe;
  logic [7:0] remaining;
  logic       done;
  logic       error;
  logic [2:0] state_out;

  modport master (
    output change_valid, change_amt, coin_done, refill,
    input  change_ready, coin_out, coin_strobe, remaining, done, error,
           state_out
  );

  modport slave (
    input  change_valid, change_amt, coin_done, refill,
    output change_ready, coin_out, coin_strobe, remaining, done, error,
           state_out
  );
endinterface

// File: rtl/change_hopper_inv.sv
// change_hopper_inv: per-denomination coin inventory (4-bit counters).
//   clk, reset   : system clock, synchronous active-high reset
//   i_refill     : load every counter with INV_INIT (caller gates to IDLE)
//   i_dec_en     : one coin of i_dec_code has been ejected
//   i_dec_code   : coin code to decrement (COIN_5/10/20)
//   o_avail[2:0] : counter non-zero; bit0=5, bit1=10, bit2=20
module change_hopper_inv
  import vending_pkg::*;
#(
  parameter int INV_INIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_refill,
  input  logic       i_dec_en,
  input  logic [1:0] i_dec_code,
  output logic [2:0] o_avail
);

  logic [2:0][3:0] r_inv;
  logic [1:0]      w_idx;

  // Coin codes 1..3 map onto counter slots 0..2.
  assign w_idx = i_dec_code - 2'd1;

  always_ff @(posedge clk) begin
    if (reset || i_refill) begin
      r_inv <= {3{4'(INV_INIT)}};
    end else if (i_dec_en && i_dec_code != COIN_NONE) begin
      // Saturate at zero; the controller never ejects from an empty slot.
      if (r_inv[w_idx] != 4'd0) r_inv[w_idx] <= r_inv[w_idx] - 4'd1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_avail
    assign o_avail[g] = |r_inv[g];
  end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin change controller (20, 10, 5).
// Accepts an amount, ejects coins one by one through a strobe/acknowledge
// handshake with the hopper, and reports done or error.
//   clk   : system clock
//   reset : synchronous active-high reset, aborts any dispense
//   bus   : change_dispenser_if.slave (request, hopper handshake, status)
// Parameters: COIN_PULSE_CYCLES (strobe width), ACK_TIMEOUT (jam limit),
//   MAX_CHANGE (largest accepted amount), INV_INIT (coins after refill).
// Build option: define HOPPER_INV_EN to build per-denomination inventory
//   counters; without it every denomination is always available and
//   refill has no effect.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int COIN_PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT       = 16,
  parameter int MAX_CHANGE        = 99,
  parameter int INV_INIT          = 8
) (
  input  logic           clk,
  input  logic           reset,
  change_dispenser_if.slave bus
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t        r_state;
  logic [1:0]    r_coin_out;
  logic          r_strobe;
  logic [7:0]    r_rem;
  logic          r_done;
  logic          r_error;
  logic          r_ready;
  logic [3:0]    r_pcnt;
  logic [TW-1:0] r_tcnt;

  logic [2:0]    w_avail;
  logic [1:0]    w_sel;
  logic          w_bad_amt;
  logic          w_dec;

  assign w_dec     = (r_state == ST_WAIT_ACK) && bus.coin_done;
  assign w_bad_amt = (bus.change_amt > 8'(MAX_CHANGE)) ||
                     ((bus.change_amt % 8'd5) != 8'd0);

`ifdef HOPPER_INV_EN
  logic w_refill;
  // Refill only lands while idle; an accept in the same cycle does not
  // touch inventory, so refill effectively applies first.
  assign w_refill = (r_state == ST_IDLE) && bus.refill;

  change_hopper_inv #(
    .INV_INIT (INV_INIT)
  ) u_inv (
    .clk        (clk),
    .reset      (reset),
    .i_refill   (w_refill),
    .i_dec_en   (w_dec),
    .i_dec_code (r_coin_out),
    .o_avail    (w_avail)
  );
`else
  logic w_unused_refill;
  assign w_unused_refill = bus.refill;
  assign w_avail         = 3'b111;
`endif

  // Largest coin not exceeding the remainder with stock left.
  always_comb begin
    w_sel = COIN_NONE;
    if      (r_rem >= VAL_20 && w_avail[2]) w_sel = COIN_20;
    else if (r_rem >= VAL_10 && w_avail[1]) w_sel = COIN_10;
    else if (r_rem >= VAL_5  && w_avail[0]) w_sel = COIN_5;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_coin_out <= COIN_NONE;
      r_strobe   <= 1'b0;
      r_rem      <= 8'd0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_ready    <= 1'b1;
      r_pcnt     <= 4'd0;
      r_tcnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.change_valid) begin
            r_ready <= 1'b0;
            r_rem   <= bus.change_amt;
            if (w_bad_amt) begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end else begin
              r_state <= ST_SELECT;
              r_error <= 1'b0;
            end
          end
        end

        ST_SELECT: begin
          if (r_rem == 8'd0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else if (w_sel != COIN_NONE) begin
            r_state    <= ST_PULSE;
            r_coin_out <= w_sel;
            r_strobe   <= 1'b1;
            r_pcnt     <= 4'(COIN_PULSE_CYCLES - 1);
          end else begin
            r_state <= ST_ERROR;
            r_error <= 1'b1;
          end
        end

        ST_PULSE: begin
          if (r_pcnt == 4'd0) begin
            r_state  <= ST_WAIT_ACK;
            r_strobe <= 1'b0;
            r_tcnt   <= '0;
          end else begin
            r_pcnt <= r_pcnt - 4'd1;
          end
        end

        ST_WAIT_ACK: begin
          if (bus.coin_done) begin
            // Selection guaranteed coin value <= r_rem, so no underflow.
            r_rem      <= r_rem - coin_value(r_coin_out);
            r_coin_out <= COIN_NONE;
            r_state    <= ST_SELECT;
          end else if (r_tcnt == TW'(ACK_TIMEOUT - 1)) begin
            r_coin_out <= COIN_NONE;
            r_state    <= ST_ERROR;
            r_error    <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end

        ST_ERROR: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end

        default: begin
          r_state    <= ST_IDLE;
          r_ready    <= 1'b1;
          r_strobe   <= 1'b0;
          r_coin_out <= COIN_NONE;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.change_ready = r_ready;
  assign bus.coin_out     = r_coin_out;
  assign bus.coin_strobe  = r_strobe;
  assign bus.remaining    = r_rem;
  assign bus.done         = r_done;
  assign bus.error        = r_error;
  assign bus.state_out    = r_state;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed, table-driven bench for change_dispenser.
// Build with or without HOPPER_INV_EN; with it the DUT runs INV_INIT=1.
module tb_change_dispenser;

`ifdef HOPPER_INV_EN
  localparam int TB_INV = 1;
`else
  localparam int TB_INV = 8;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  change_dispenser_if bus ();

  change_dispenser #(
    .COIN_PULSE_CYCLES (4),
    .ACK_TIMEOUT       (16),
    .MAX_CHANGE        (99),
    .INV_INIT          (TB_INV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Observations of one request.
  int         obs_n;
  logic [1:0] obs_seq [4];
  logic       obs_done;
  int         obs_strobe_w;
  int         obs_wait_cycles;

  typedef struct {
    logic [7:0] amt;
    int         n;
    logic [1:0] c0, c1, c2;
    logic       err;
    logic [7:0] rem;
    logic       dn;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_refill();
    @(negedge clk);
    bus.refill = 1'b1;
    @(negedge clk);
    bus.refill = 1'b0;
  endtask

  // Issue one request, answer each coin 2 cycles into WAIT_ACK when
  // respond is set, and run until the controller is back in IDLE.
  task automatic run_req(input logic [7:0] amt, input bit respond);
    bit   prev_strobe = 1'b0;
    bit   finished    = 1'b0;
    int   wcnt        = 0;
    int   sw          = 0;
    obs_n = 0;
    obs_done = 1'b0;
    obs_strobe_w = 0;
    obs_wait_cycles = 0;
    for (int i = 0; i < 4; i++) obs_seq[i] = 2'b00;
    @(negedge clk);
    bus.change_valid = 1'b1;
    bus.change_amt   = amt;
    @(negedge clk);
    bus.change_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (bus.coin_strobe) begin
        if (!prev_strobe) begin
          if (obs_n < 4) obs_seq[obs_n] = bus.coin_out;
          obs_n++;
          sw = 0;
        end
        sw++;
        if (obs_n == 1) obs_strobe_w = sw;
      end
      prev_strobe = bus.coin_strobe;
      if (bus.done) obs_done = 1'b1;
      if (bus.state_out == 3'd3) begin
        wcnt++;
        obs_wait_cycles++;
        bus.coin_done = respond && (wcnt == 2);
      end else begin
        wcnt = 0;
        bus.coin_done = 1'b0;
      end
      if (bus.state_out == 3'd0) begin
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.coin_done = 1'b0;
    if (!finished) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: amt=%0d never returned to idle", amt);
    end
  endtask

  initial begin
    bus.change_valid = 1'b0;
    bus.change_amt   = 8'd0;
    bus.coin_done    = 1'b0;
    bus.refill       = 1'b0;
    reset            = 1'b1;

    //            amt    n  c0     c1     c2    err  rem     dn
    tbl[0] = '{8'd35,  3, 2'b11, 2'b10, 2'b01, 1'b0, 8'd0,   1'b1};
    tbl[1] = '{8'd0,   0, 2'b00, 2'b00, 2'b00, 1'b0, 8'd0,   1'b1};
    tbl[2] = '{8'd7,   0, 2'b00, 2'b00, 2'b00, 1'b1, 8'd7,   1'b0};
    tbl[3] = '{8'd25,  2, 2'b11, 2'b01, 2'b00, 1'b0, 8'd0,   1'b1};
    tbl[4] = '{8'd15,  2, 2'b10, 2'b01, 2'b00, 1'b0, 8'd0,   1'b1};
    tbl[5] = '{8'd100, 0, 2'b00, 2'b00, 2'b00, 1'b1, 8'd100, 1'b0};
    tbl[6] = '{8'd30,  2, 2'b11, 2'b10, 2'b00, 1'b0, 8'd0,   1'b1};
    tbl[7] = '{8'd5,   1, 2'b01, 2'b00, 2'b00, 1'b0, 8'd0,   1'b1};
    tbl[8] = '{8'd99,  0, 2'b00, 2'b00, 2'b00, 1'b1, 8'd99,  1'b0};
    tbl[9] = '{8'd95,  0, 2'b00, 2'b00, 2'b00, 1'b0, 8'd0,   1'b1};
`ifdef HOPPER_INV_EN
    tbl[9] = '{8'd95,  3, 2'b11, 2'b10, 2'b01, 1'b1, 8'd60,  1'b0};
`else
    tbl[9] = '{8'd95,  6, 2'b11, 2'b11, 2'b11, 1'b0, 8'd0,   1'b1};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_state", int'(bus.state_out), 0);
    chk("rst_ready", int'(bus.change_ready), 1);
    chk("rst_strobe", int'(bus.coin_strobe), 0);
    chk("rst_coin", int'(bus.coin_out), 0);
    chk("rst_rem", int'(bus.remaining), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.error), 0);

    // Table-driven requests
    foreach (tbl[k]) begin
      do_refill();
      run_req(tbl[k].amt, 1'b1);
      chk($sformatf("v%0d_ncoins", k), obs_n, tbl[k].n);
      chk($sformatf("v%0d_c0", k), int'(obs_seq[0]), int'(tbl[k].c0));
      chk($sformatf("v%0d_c1", k), int'(obs_seq[1]), int'(tbl[k].c1));
      chk($sformatf("v%0d_c2", k), int'(obs_seq[2]), int'(tbl[k].c2));
      chk($sformatf("v%0d_err", k), int'(bus.error), int'(tbl[k].err));
      chk($sformatf("v%0d_rem", k), int'(bus.remaining), int'(tbl[k].rem));
      chk($sformatf("v%0d_done", k), int'(obs_done), int'(tbl[k].dn));
      if (tbl[k].n > 0) chk($sformatf("v%0d_strobe_w", k), obs_strobe_w, 4);
    end

    // Request 0: done exactly two cycles after acceptance
    do_refill();
    @(negedge clk);
    bus.change_valid = 1'b1;
    bus.change_amt   = 8'd0;
    @(negedge clk);
    bus.change_valid = 1'b0;
    chk("z_sel_state", int'(bus.state_out), 1);
    chk("z_done_early", int'(bus.done), 0);
    @(negedge clk);
    chk("z_done", int'(bus.done), 1);
    chk("z_strobe", int'(bus.coin_strobe), 0);
    @(negedge clk);
    chk("z_done_off", int'(bus.done), 0);
    chk("z_idle", int'(bus.state_out), 0);

    // Request 7: ERROR on the next cycle, then IDLE with error held
    @(negedge clk);
    bus.change_valid = 1'b1;
    bus.change_amt   = 8'd7;
    @(negedge clk);
    bus.change_valid = 1'b0;
    chk("b_state", int'(bus.state_out), 5);
    chk("b_err", int'(bus.error), 1);
    chk("b_rem", int'(bus.remaining), 7);
    chk("b_strobe", int'(bus.coin_strobe), 0);
    @(negedge clk);
    chk("b_idle", int'(bus.state_out), 0);
    chk("b_err_held", int'(bus.error), 1);

    // Jam: 4 strobe cycles, 16 WAIT_ACK cycles, then error
    do_refill();
    run_req(8'd20, 1'b0);
    chk("jam_ncoins", obs_n, 1);
    chk("jam_strobe_w", obs_strobe_w, 4);
    chk("jam_wait", obs_wait_cycles, 16);
    chk("jam_err", int'(bus.error), 1);
    chk("jam_rem", int'(bus.remaining), 20);
    chk("jam_state", int'(bus.state_out), 0);
    chk("jam_done", int'(obs_done), 0);

    // Inventory exhaustion / availability
    do_refill();
    run_req(8'd45, 1'b1);
`ifdef HOPPER_INV_EN
    chk("inv_ncoins", obs_n, 3);
    chk("inv_c0", int'(obs_seq[0]), 3);
    chk("inv_c1", int'(obs_seq[1]), 2);
    chk("inv_c2", int'(obs_seq[2]), 1);
    chk("inv_err", int'(bus.error), 1);
    chk("inv_rem", int'(bus.remaining), 10);
    // No refill: every slot empty, so the next request fails in SELECT
    run_req(8'd5, 1'b1);
    chk("empty_ncoins", obs_n, 0);
    chk("empty_err", int'(bus.error), 1);
    chk("empty_rem", int'(bus.remaining), 5);
`else
    chk("inv_ncoins", obs_n, 3);
    chk("inv_c0", int'(obs_seq[0]), 3);
    chk("inv_c1", int'(obs_seq[1]), 3);
    chk("inv_c2", int'(obs_seq[2]), 1);
    chk("inv_err", int'(bus.error), 0);
    chk("inv_rem", int'(bus.remaining), 0);
`endif

    // Reset in the middle of PULSE
    do_refill();
    @(negedge clk);
    bus.change_valid = 1'b1;
    bus.change_amt   = 8'd35;
    @(negedge clk);
    bus.change_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mr_in_pulse", int'(bus.coin_strobe), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_strobe", int'(bus.coin_strobe), 0);
    chk("mr_rem", int'(bus.remaining), 0);
    chk("mr_ready", int'(bus.change_ready), 1);
    chk("mr_state", int'(bus.state_out), 0);
    chk("mr_coin", int'(bus.coin_out), 0);
    reset = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
